// File: rtl/pipeline_types_pkg.sv
// Shared pipeline types: load kinds and the write-back stage pipeline register layout.
package PipelineTypes;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd3,
    LHU = 3'd4
  } LoadType;

  typedef struct packed {
    logic                  valid;
    logic                  wEnable;
    logic [REG_ADDR_W-1:0] rdAddr;
    logic [XLEN-1:0]       aluResult;
    logic                  isLoad;
    LoadType               loadType;
  } WriteBackStagePipeReg;

endpackage

// File: rtl/write_back_stage_load_aligner.sv
// Extracts and extends the addressed byte/halfword/word from a read word and
// flags accesses that are not naturally aligned for their size.
module load_aligner
  import PipelineTypes::*;
(
  input  logic [XLEN-1:0] rData,
  input  logic [1:0]      offset,
  input  LoadType         loadType,
  output logic [XLEN-1:0] alignedData,
  output logic            misalignedAccess
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    byteSel          = rData[7:0];
    halfSel          = offset[1] ? rData[31:16] : rData[15:0];
    alignedData      = rData;
    misalignedAccess = 1'b0;

    case (offset)
      2'd0:    byteSel = rData[7:0];
      2'd1:    byteSel = rData[15:8];
      2'd2:    byteSel = rData[23:16];
      default: byteSel = rData[31:24];
    endcase

    case (loadType)
      LB:  alignedData = {{24{byteSel[7]}}, byteSel};
      LBU: alignedData = {24'd0, byteSel};
      LH: begin
        alignedData      = {{16{halfSel[15]}}, halfSel};
        misalignedAccess = offset[0];
      end
      LHU: begin
        alignedData      = {16'd0, halfSel};
        misalignedAccess = offset[0];
      end
      LW: begin
        alignedData      = rData;
        misalignedAccess = (offset != 2'd0);
      end
      default: alignedData = rData;
    endcase
  end

endmodule

// File: rtl/write_back_stage.sv
// Write-back stage: pipeline register, stall-safe load-data hold, alignment,
// register-file write/forwarding and retired-instruction counting.
module write_back_stage
  import PipelineTypes::*;
#(
  parameter int unsigned INSTRET_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inValid,
  input  logic                  inWEnable,
  input  logic [4:0]            inRdAddr,
  input  logic [31:0]           inAluResult,
  input  logic                  inIsLoad,
  input  LoadType               inLoadType,
  input  logic [31:0]           memRData,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  rfWEnable,
  output logic [4:0]            rfWAddr,
  output logic [31:0]           rfWData,
  output logic                  fwdValid,
  output logic [4:0]            fwdAddr,
  output logic [31:0]           fwdData,
  output logic                  misaligned,
  output logic                  retire,
  output logic [INSTRET_W-1:0]  instret
);

  WriteBackStagePipeReg pipeQ;
  logic [XLEN-1:0]      holdWord;
  logic                 heldFlag;
  logic [XLEN-1:0]      readWord;
  logic [XLEN-1:0]      alignedData;
  logic                 alignMis;
  logic                 canWrite;

  // Pipeline register; flush overrides both load and hold of the valid bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipeQ <= '0;
    end else begin
      if (!stall) begin
        pipeQ.valid     <= inValid;
        pipeQ.wEnable   <= inWEnable;
        pipeQ.rdAddr    <= inRdAddr;
        pipeQ.aluResult <= inAluResult;
        pipeQ.isLoad    <= inIsLoad;
        pipeQ.loadType  <= inLoadType;
      end
      if (flush) begin
        pipeQ.valid <= 1'b0;
      end
    end
  end

  // The memory word is only valid in the first occupancy cycle; keep a copy across stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      holdWord <= '0;
      heldFlag <= 1'b0;
    end else if (!stall) begin
      heldFlag <= 1'b0;
    end else if (!heldFlag) begin
      holdWord <= memRData;
      heldFlag <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instret <= '0;
    end else if (retire) begin
      instret <= instret + INSTRET_W'(1);
    end
  end

  assign readWord = heldFlag ? holdWord : memRData;

  load_aligner uAligner (
    .rData            (readWord),
    .offset           (pipeQ.aluResult[1:0]),
    .loadType         (pipeQ.loadType),
    .alignedData      (alignedData),
    .misalignedAccess (alignMis)
  );

  always_comb begin
    misaligned = pipeQ.valid && pipeQ.isLoad && alignMis;
    canWrite   = pipeQ.valid && pipeQ.wEnable && (pipeQ.rdAddr != 5'd0) && !misaligned;
    rfWData    = pipeQ.isLoad ? alignedData : pipeQ.aluResult;
    rfWAddr    = pipeQ.rdAddr;
    rfWEnable  = canWrite && !stall;
    fwdValid   = canWrite;
    fwdAddr    = rfWAddr;
    fwdData    = rfWData;
    retire     = pipeQ.valid && !stall;
  end

endmodule

// File: tb/tb_write_back_stage.sv
// Bench for write_back_stage: directed corner cases plus random traffic checked
// against an instruction-level reference model; a second 8-bit-counter build checks wrap.
module tb_write_back_stage;
  import PipelineTypes::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        inValid, inWEnable, inIsLoad, stall, flush;
  logic [4:0]  inRdAddr;
  logic [31:0] inAluResult, memRData;
  LoadType     inLoadType;

  logic        rfWEnable, fwdValid, misaligned, retire;
  logic [4:0]  rfWAddr, fwdAddr;
  logic [31:0] rfWData, fwdData;
  logic [63:0] instret;

  logic        rfWEnable8, fwdValid8, misaligned8, retire8;
  logic [4:0]  rfWAddr8, fwdAddr8;
  logic [31:0] rfWData8, fwdData8;
  logic [7:0]  instret8;

  write_back_stage dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inWEnable(inWEnable), .inRdAddr(inRdAddr),
    .inAluResult(inAluResult), .inIsLoad(inIsLoad), .inLoadType(inLoadType),
    .memRData(memRData), .stall(stall), .flush(flush),
    .rfWEnable(rfWEnable), .rfWAddr(rfWAddr), .rfWData(rfWData),
    .fwdValid(fwdValid), .fwdAddr(fwdAddr), .fwdData(fwdData),
    .misaligned(misaligned), .retire(retire), .instret(instret)
  );

  write_back_stage #(.INSTRET_W(8)) dut8 (
    .clk(clk), .rst(rst), .inValid(inValid), .inWEnable(inWEnable), .inRdAddr(inRdAddr),
    .inAluResult(inAluResult), .inIsLoad(inIsLoad), .inLoadType(inLoadType),
    .memRData(memRData), .stall(stall), .flush(flush),
    .rfWEnable(rfWEnable8), .rfWAddr(rfWAddr8), .rfWData(rfWData8),
    .fwdValid(fwdValid8), .fwdAddr(fwdAddr8), .fwdData(fwdData8),
    .misaligned(misaligned8), .retire(retire8), .instret(instret8)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: the instruction currently in the stage and its memory word.
  bit              mValid, mWen, mIsLoad, mFirst;
  logic [4:0]      mRd;
  logic [31:0]     mAlu, mWord, nWord, garbage;
  LoadType         mType;
  longint unsigned mCount;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] refLoad(input LoadType t, input logic [31:0] w, input logic [1:0] off);
    logic [31:0] sh;
    sh = w >> (8 * off);
    case (t)
      LB:      return 32'($signed(sh[7:0]));
      LBU:     return 32'(sh[7:0]);
      LH:      return 32'($signed(sh[15:0]));
      LHU:     return 32'(sh[15:0]);
      default: return w;
    endcase
  endfunction

  task automatic drive(input bit v, input bit we, input logic [4:0] rd, input logic [31:0] alu,
                       input bit ld, input LoadType t, input bit st, input bit fl,
                       input logic [31:0] word);
    inValid = v; inWEnable = we; inRdAddr = rd; inAluResult = alu;
    inIsLoad = ld; inLoadType = t; stall = st; flush = fl; nWord = word;
    memRData = mFirst ? mWord : garbage;
  endtask

  task automatic idle(input bit st);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, LB, st, 1'b0, $urandom);
  endtask

  task automatic chkZero(input string tag);
    chk({tag, "_we"}, 64'(rfWEnable), 64'd0);
    chk({tag, "_waddr"}, 64'(rfWAddr), 64'd0);
    chk({tag, "_wdata"}, 64'(rfWData), 64'd0);
    chk({tag, "_fv"}, 64'(fwdValid), 64'd0);
    chk({tag, "_fa"}, 64'(fwdAddr), 64'd0);
    chk({tag, "_fd"}, 64'(fwdData), 64'd0);
    chk({tag, "_mis"}, 64'(misaligned), 64'd0);
    chk({tag, "_ret"}, 64'(retire), 64'd0);
    chk({tag, "_inst"}, instret, 64'd0);
    chk({tag, "_inst8"}, 64'(instret8), 64'd0);
  endtask

  // Check outputs for the current cycle, then advance one clock and update the model.
  task automatic step();
    logic [1:0]  off;
    bit          expMis, expFwd;
    logic [31:0] expData;
    #1;
    off     = mAlu[1:0];
    expMis  = mValid && mIsLoad && (((mType == LH || mType == LHU) && off[0]) ||
                                    (mType == LW && off != 2'd0));
    expFwd  = mValid && mWen && (mRd != 5'd0) && !expMis;
    expData = mIsLoad ? refLoad(mType, mWord, off) : mAlu;
    chk("rfWEnable", 64'(rfWEnable), 64'(expFwd && !stall));
    chk("fwdValid", 64'(fwdValid), 64'(expFwd));
    chk("misaligned", 64'(misaligned), 64'(expMis));
    chk("retire", 64'(retire), 64'(mValid && !stall));
    chk("retire8", 64'(retire8), 64'(mValid && !stall));
    chk("instret", instret, 64'(mCount));
    chk("instret8", 64'(instret8), 64'(mCount[7:0]));
    if (expFwd) begin
      chk("rfWAddr", 64'(rfWAddr), 64'(mRd));
      chk("rfWData", 64'(rfWData), 64'(expData));
      chk("fwdAddr", 64'(fwdAddr), 64'(mRd));
      chk("fwdData", 64'(fwdData), 64'(expData));
    end
    @(posedge clk);
    if (mValid && !stall) mCount++;
    if (!stall) begin
      mValid = inValid && !flush; mWen = inWEnable; mRd = inRdAddr; mAlu = inAluResult;
      mIsLoad = inIsLoad; mType = inLoadType; mWord = nWord; mFirst = 1'b1;
    end else begin
      mFirst = 1'b0;
      if (flush) mValid = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    mValid = 0; mWen = 0; mIsLoad = 0; mFirst = 0; mRd = '0; mAlu = '0;
    mWord = '0; nWord = '0; mType = LB; mCount = 0; garbage = 32'h5A5A_1234;
    rst = 1'b0;
    drive(1'b1, 1'b1, 5'd9, 32'hFFFF_FFFF, 1'b1, LW, 1'b1, 1'b0, 32'hFFFF_FFFF);
    #1 chkZero("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // ALU op rd=5 -> write 0x1234 one cycle later, counter 0 -> 1
    drive(1'b1, 1'b1, 5'd5, 32'h1234, 1'b0, LB, 1'b0, 1'b0, $urandom);
    step();
    idle(1'b0);
    #1 chk("alu_we", 64'(rfWEnable), 64'd1);
    chk("alu_data", 64'(rfWData), 64'h1234);
    step();
    chk("alu_instret", instret, 64'd1);

    // Byte loads from offset 3
    drive(1'b1, 1'b1, 5'd3, 32'h0000_0203, 1'b1, LB, 1'b0, 1'b0, 32'h80FF_0000);
    step();
    idle(1'b0);
    #1 chk("lb_data", 64'(rfWData), 64'hFFFF_FF80);
    step();
    drive(1'b1, 1'b1, 5'd3, 32'h0000_0203, 1'b1, LBU, 1'b0, 1'b0, 32'h80FF_0000);
    step();
    idle(1'b0);
    #1 chk("lbu_data", 64'(rfWData), 64'h0000_0080);
    step();

    // LW held across a 3-cycle stall while the memory word disappears
    drive(1'b1, 1'b1, 5'd7, 32'h0000_0100, 1'b1, LW, 1'b0, 1'b0, 32'hCAFE_BABE);
    step();
    garbage = 32'd0;
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      #1 chk("lw_stall_fv", 64'(fwdValid), 64'd1);
      chk("lw_stall_fd", 64'(fwdData), 64'hCAFE_BABE);
      chk("lw_stall_we", 64'(rfWEnable), 64'd0);
      step();
    end
    idle(1'b0);
    #1 chk("lw_rel_data", 64'(rfWData), 64'hCAFE_BABE);
    step();
    idle(1'b0);
    #1 chk("lw_once", 64'(rfWEnable), 64'd0);
    step();
    garbage = 32'h5A5A_1234;

    // Misaligned halfword, then a write to x0
    drive(1'b1, 1'b1, 5'd4, 32'h0000_0101, 1'b1, LH, 1'b0, 1'b0, $urandom);
    step();
    idle(1'b0);
    #1 chk("mis_flag", 64'(misaligned), 64'd1);
    chk("mis_we", 64'(rfWEnable), 64'd0);
    chk("mis_ret", 64'(retire), 64'd1);
    step();
    drive(1'b1, 1'b1, 5'd0, 32'hABCD, 1'b0, LB, 1'b0, 1'b0, $urandom);
    step();
    idle(1'b0);
    #1 chk("x0_we", 64'(rfWEnable), 64'd0);
    chk("x0_ret", 64'(retire), 64'd1);
    step();

    // stall+flush kills the occupant; flush alone retires it and inserts a bubble
    drive(1'b1, 1'b1, 5'd9, 32'h99, 1'b0, LB, 1'b0, 1'b0, $urandom);
    step();
    drive(1'b1, 1'b1, 5'd10, 32'hAA, 1'b0, LB, 1'b1, 1'b1, $urandom);
    step();
    idle(1'b0);
    #1 chk("sf_ret", 64'(retire), 64'd0);
    chk("sf_we", 64'(rfWEnable), 64'd0);
    step();
    drive(1'b1, 1'b1, 5'd11, 32'hBB, 1'b0, LB, 1'b0, 1'b0, $urandom);
    step();
    drive(1'b1, 1'b1, 5'd12, 32'hCC, 1'b0, LB, 1'b0, 1'b1, $urandom);
    #1 chk("f_ret", 64'(retire), 64'd1);
    step();
    idle(1'b0);
    #1 chk("f_bubble", 64'(retire), 64'd0);
    step();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      garbage = $urandom;
      drive(($urandom % 4) != 0, 1'($urandom), 5'($urandom), $urandom, 1'($urandom),
            LoadType'(3'($urandom_range(0, 4))), ($urandom % 4) == 0, ($urandom % 12) == 0,
            $urandom);
      step();
    end

    // Drive the 8-bit counter to all-ones, then one more retire wraps it
    for (int i = 0; i < 300 && mCount[7:0] != 8'hFF; i++) begin
      drive(1'b1, 1'b0, 5'd1, $urandom, 1'b0, LB, 1'b0, 1'b0, $urandom);
      step();
    end
    #1 chk("pre_wrap", 64'(instret8), 64'hFF);
    step();
    idle(1'b0);
    #1 chk("wrap", 64'(instret8), 64'd0);
    step();

    // Reset during a stalled occupancy discards everything
    drive(1'b1, 1'b1, 5'd13, 32'h0000_0200, 1'b1, LW, 1'b0, 1'b0, 32'h1357_9BDF);
    step();
    idle(1'b1);
    step();
    rst = 1'b0;
    #1 chkZero("rst_mid");
    mValid = 0; mFirst = 0; mCount = 0; mWord = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b1, 5'd6, 32'h600D, 1'b0, LB, 1'b0, 1'b0, $urandom);
    step();
    idle(1'b0);
    #1 chk("post_rst_data", 64'(rfWData), 64'h600D);
    chk("post_rst_we", 64'(rfWEnable), 64'd1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
